keypad_scanner: RTL and testbench

//  Row-scanning reader for a 4x4 matrix keypad; the input-side counterpart of the display's row/anode multiplex scan.

---
 rtl/keypad_pkg.sv | 36 +++
 rtl/keypad_sync2.sv | 26 ++
 rtl/keypad_scanner.sv | 195 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types, sizes and helpers for the 4x4 keypad row scanner.
package keypad_pkg;

    localparam int unsigned KP_ROWS   = 4;
    localparam int unsigned KP_COLS   = 4;
    localparam int unsigned KP_ROW_W  = 2;
    localparam int unsigned KP_COL_W  = 2;
    localparam int unsigned KP_CODE_W = KP_ROW_W + KP_COL_W;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } kp_state_e;

    typedef struct packed {
        logic [KP_ROW_W-1:0] row;
        logic [KP_COL_W-1:0] col;
    } kp_code_t;

    // Active-low one-hot row drive pattern for a row index.
    function automatic logic [KP_ROWS-1:0] row_onehot_n(input logic [KP_ROW_W-1:0] idx);
        return ~(KP_ROWS'(1) << idx);
    endfunction

    // Index of the lowest column line that is pulled low.
    function automatic logic [KP_COL_W-1:0] lowest_low_col(input logic [KP_COLS-1:0] cols);
        logic [KP_COL_W-1:0] idx;
        idx = '0;
        for (int i = int'(KP_COLS) - 1; i >= 0; i--) begin
            if (!cols[i]) idx = KP_COL_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_sync2.sv
// Two-flop synchronizer for asynchronous active-low inputs; resets to all ones (idle lines).
module keypad_sync2 #(
    parameter int unsigned W = 4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner with per-key debounce and single-code reporting.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES   = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned REPEAT_DELAY    = 500000,
    parameter int unsigned REPEAT_PERIOD   = 100000
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic [KP_COLS-1:0]   Col,
    output logic [KP_ROWS-1:0]   Row,
    output logic [KP_ROW_W-1:0]  RowSelect,
    output logic [KP_CODE_W-1:0] KeyCode,
    output logic                 KeyValid,
    output logic                 KeyHeld
);

    localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES + 1);

    if (SETTLE_CYCLES < 3 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("keypad_scanner: illegal parameter set");
    end

    logic [KP_COLS-1:0]  col_s;
    kp_state_e           state_q, state_d;
    logic [KP_ROW_W-1:0] row_q, row_d;
    logic [KP_ROWS-1:0]  row_n_q, row_n_d;
    logic [KP_COL_W-1:0] col_q, col_d;
    logic [SET_W-1:0]    set_cnt_q, set_cnt_d;
    logic [DEB_W-1:0]    deb_cnt_q, deb_cnt_d;
    kp_code_t            code_q, code_d;
    logic                valid_q, valid_d;
    logic                held_q, held_d;
    logic [KP_ROW_W-1:0] next_row_c;
    logic                release_c;

    keypad_sync2 #(.W(KP_COLS)) u_col_sync (
        .clk_i   (Clock),
        .rst_n_i (Reset_n),
        .d_i     (Col),
        .q_o     (col_s)
    );

    assign next_row_c = row_q + KP_ROW_W'(1);
    assign release_c  = (state_q == HELD) && col_s[col_q]
                        && (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1));

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

    // Repeat timer runs from press acceptance; bounces in HELD do not touch it.
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_first_q, rep_first_d;
    logic             rep_fire_c;

    assign rep_fire_c = rep_first_q ? (rep_cnt_q == REP_W'(REPEAT_DELAY - 1))
                                    : (rep_cnt_q == REP_W'(REPEAT_PERIOD - 1));

    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        if (state_q != HELD) begin
            rep_cnt_d   = '0;
            rep_first_d = 1'b1;
        end else if (!release_c) begin
            if (rep_fire_c) begin
                rep_cnt_d   = '0;
                rep_first_d = 1'b0;
            end else begin
                rep_cnt_d = rep_cnt_q + REP_W'(1);
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
        end
    end
`endif

    // Next-state and registered-output logic for the scan/debounce/held FSM.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        row_n_d   = row_n_q;
        col_d     = col_q;
        set_cnt_d = set_cnt_q;
        deb_cnt_d = deb_cnt_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        held_d    = held_q;

        case (state_q)
            SCAN: begin
                if (set_cnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
                    set_cnt_d = '0;
                    if (&col_s) begin
                        row_d   = next_row_c;
                        row_n_d = row_onehot_n(next_row_c);
                    end else begin
                        col_d     = lowest_low_col(col_s);
                        deb_cnt_d = '0;
                        state_d   = DEBOUNCE;
                    end
                end else begin
                    set_cnt_d = set_cnt_q + SET_W'(1);
                end
            end

            DEBOUNCE: begin
                if (col_s[col_q]) begin
                    state_d   = SCAN;
                    row_d     = next_row_c;
                    row_n_d   = row_onehot_n(next_row_c);
                    set_cnt_d = '0;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                    state_d    = HELD;
                    code_d.row = row_q;
                    code_d.col = col_q;
                    valid_d    = 1'b1;
                    held_d     = 1'b1;
                    deb_cnt_d  = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end

            HELD: begin
                if (release_c) begin
                    state_d   = SCAN;
                    held_d    = 1'b0;
                    row_d     = next_row_c;
                    row_n_d   = row_onehot_n(next_row_c);
                    set_cnt_d = '0;
                    deb_cnt_d = '0;
                end else if (col_s[col_q]) begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end else begin
                    deb_cnt_d = '0;
                end
`ifdef KEYPAD_REPEAT_EN
                if (!release_c && rep_fire_c) valid_d = 1'b1;
`endif
            end

            default: begin
                state_d   = SCAN;
                set_cnt_d = '0;
                deb_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= SCAN;
            row_q     <= '0;
            row_n_q   <= row_onehot_n('0);
            col_q     <= '0;
            set_cnt_q <= '0;
            deb_cnt_q <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            row_n_q   <= row_n_d;
            col_q     <= col_d;
            set_cnt_q <= set_cnt_d;
            deb_cnt_q <= deb_cnt_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            held_q    <= held_d;
        end
    end

    assign Row       = row_n_q;
    assign RowSelect = row_q;
    assign KeyCode   = code_q;
    assign KeyValid  = valid_q;
    assign KeyHeld   = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a key-matrix model drives Col from the DUT's Row output.
module tb_keypad_scanner;

    logic       Clock;
    logic       Reset_n;
    logic [3:0] Col;
    logic [3:0] Row;
    logic [1:0] RowSelect;
    logic [3:0] KeyCode;
    logic       KeyValid;
    logic       KeyHeld;

    logic [15:0] pressed;      // bit r*4+c = key at row r, column c
    int          n_checks;
    int          n_fails;
    int          cyc;
    int          pulse_cnt;
    int          pulse_cyc [32];

    keypad_scanner #(
        .SETTLE_CYCLES   (4),
        .DEBOUNCE_CYCLES (8),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (10)
    ) dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .Col       (Col),
        .Row       (Row),
        .RowSelect (RowSelect),
        .KeyCode   (KeyCode),
        .KeyValid  (KeyValid),
        .KeyHeld   (KeyHeld)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // A pressed key shorts its column low only while its row is driven low.
    always_comb begin
        Col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !Row[r]) Col[c] = 1'b0;
    end

    always @(posedge Clock) begin
        cyc <= cyc + 1;
        if (Reset_n && KeyValid === 1'b1) begin
            if (pulse_cnt < 32) pulse_cyc[pulse_cnt] <= cyc;
            pulse_cnt <= pulse_cnt + 1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int max, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge Clock);
            if (KeyValid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_fall(input int max, output int n);
        n = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge Clock);
            if (KeyHeld === 1'b0) begin
                n = i + 1;
                break;
            end
        end
    endtask

    logic [3:0] row_pat [4];
    logic       ok;
    int         n;
    int         base;
    int         exp_off [6];

    initial begin
        row_pat   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_off   = '{0, 20, 30, 40, 50, 60};
        n_checks  = 0;
        n_fails   = 0;
        cyc       = 0;
        pulse_cnt = 0;
        pressed   = '0;
        Reset_n   = 1'b0;

        // Reset values
        repeat (3) @(negedge Clock);
        check("rst_row", 32'(Row), 32'h0000_000E);
        check("rst_rowsel", 32'(RowSelect), 32'd0);
        check("rst_code", 32'(KeyCode), 32'd0);
        check("rst_valid", 32'(KeyValid), 32'd0);
        check("rst_held", 32'(KeyHeld), 32'd0);

        // 1: idle scan, four cycles per row, wrapping 3 -> 0
        Reset_n = 1'b1;
        #1;
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) @(negedge Clock);
            check($sformatf("scan_row_k%0d", k), 32'(Row), 32'(row_pat[(k / 4) % 4]));
            check($sformatf("scan_sel_k%0d", k), 32'(RowSelect), 32'((k / 4) % 4));
            check($sformatf("scan_valid_k%0d", k), 32'(KeyValid), 32'd0);
        end

        // 2: row 2 / col 1 -> code 9, release ends HELD 10 edges later, scan resumes at row 3
        base = pulse_cnt;
        pressed[9] = 1'b1;
        wait_valid(100, ok);
        check("t2_valid_seen", 32'(ok), 32'd1);
        check("t2_code", 32'(KeyCode), 32'h9);
        check("t2_held_rise", 32'(KeyHeld), 32'd1);
        check("t2_rowsel_held", 32'(RowSelect), 32'd2);
        @(negedge Clock);
        check("t2_valid_one_cycle", 32'(KeyValid), 32'd0);
        repeat (7) @(negedge Clock);
        check("t2_held_during", 32'(KeyHeld), 32'd1);
        pressed[9] = 1'b0;
        wait_fall(40, n);
        check("t2_release_latency", 32'(n), 32'd10);
        check("t2_resume_rowsel", 32'(RowSelect), 32'd3);
        check("t2_resume_row", 32'(Row), 32'h7);
        check("t2_code_hold", 32'(KeyCode), 32'h9);
        check("t2_pulses", 32'(pulse_cnt - base), 32'd1);

        // 3: row 1 / col 0 bouncing, then stable -> a single accept
        repeat (5) @(negedge Clock);
        base = pulse_cnt;
        for (int i = 0; i < 7; i++) begin
            pressed[4] = ~pressed[4];
            repeat (3) @(negedge Clock);
        end
        check("t3_no_valid_bounce", 32'(pulse_cnt - base), 32'd0);
        pressed[4] = 1'b1;
        wait_valid(100, ok);
        check("t3_valid_seen", 32'(ok), 32'd1);
        check("t3_code", 32'(KeyCode), 32'h4);
        repeat (2) @(negedge Clock);
        pressed[4] = 1'b0;
        wait_fall(40, n);
        check("t3_release_seen", 32'(n > 0), 32'd1);
        check("t3_pulses", 32'(pulse_cnt - base), 32'd1);

        // 4: row 3 with cols 0 and 3 -> code C; col 3 release alone keeps HELD
        repeat (5) @(negedge Clock);
        base = pulse_cnt;
        pressed[12] = 1'b1;
        pressed[15] = 1'b1;
        wait_valid(100, ok);
        check("t4_valid_seen", 32'(ok), 32'd1);
        check("t4_code", 32'(KeyCode), 32'hC);
        @(negedge Clock);
        pressed[15] = 1'b0;
        repeat (12) @(negedge Clock);
        check("t4_held_after_col3", 32'(KeyHeld), 32'd1);
        check("t4_code_after_col3", 32'(KeyCode), 32'hC);
        pressed[12] = 1'b0;
        wait_fall(40, n);
        check("t4_release_latency", 32'(n), 32'd10);
`ifdef KEYPAD_REPEAT_EN
        check("t4_pulses", 32'(pulse_cnt - base), 32'd2);
`else
        check("t4_pulses", 32'(pulse_cnt - base), 32'd1);
`endif

        // 5: asynchronous reset while HELD
        repeat (5) @(negedge Clock);
        pressed[2] = 1'b1;
        wait_valid(100, ok);
        check("t5_valid_seen", 32'(ok), 32'd1);
        repeat (2) @(negedge Clock);
        check("t5_held_before", 32'(KeyHeld), 32'd1);
        #2 Reset_n = 1'b0;
        #1;
        check("t5_async_row", 32'(Row), 32'hE);
        check("t5_async_rowsel", 32'(RowSelect), 32'd0);
        check("t5_async_held", 32'(KeyHeld), 32'd0);
        check("t5_async_code", 32'(KeyCode), 32'd0);
        check("t5_async_valid", 32'(KeyValid), 32'd0);
        pressed[2] = 1'b0;
        @(negedge Clock);
        Reset_n = 1'b1;
        base = pulse_cnt;
        repeat (40) @(negedge Clock);
        check("t5_no_spurious", 32'(pulse_cnt - base), 32'd0);
        check("t5_held_after", 32'(KeyHeld), 32'd0);

        // 6: long hold on row 0 / col 3; auto-repeat only when enabled
        base = pulse_cnt;
        pressed[3] = 1'b1;
        wait_valid(100, ok);
        check("t6_valid_seen", 32'(ok), 32'd1);
        repeat (55) @(negedge Clock);
        pressed[3] = 1'b0;
        wait_fall(40, n);
        check("t6_release_latency", 32'(n), 32'd10);
        repeat (25) @(negedge Clock);
        check("t6_code", 32'(KeyCode), 32'h3);
`ifdef KEYPAD_REPEAT_EN
        check("t6_pulses", 32'(pulse_cnt - base), 32'd6);
        if (pulse_cnt - base == 6 && base + 6 <= 32) begin
            for (int i = 1; i < 6; i++)
                check($sformatf("t6_offset_%0d", i),
                      32'(pulse_cyc[base+i] - pulse_cyc[base]), 32'(exp_off[i]));
        end
`else
        check("t6_pulses", 32'(pulse_cnt - base), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
